note_tone_gen: RTL and testbench

NOTE_TONE_GEN -- requirements
Module: note_tone_gen

---
 rtl/note_tone_gen.sv | 159 +++++++++++++++
 tb/tb_note_tone_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_gen.sv
// Musical note to square-wave tone generator: looks up the base pitch, scales it by
// octave, divides it into a half-period with a restoring divider and drives tone_out.
module note_tone_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int OCT_W  = 2,
  parameter int FREQ_W = 20,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        note,
  input  logic [OCT_W-1:0]  octave,
  input  logic              enable,
  output logic [FREQ_W-1:0] freq,
  output logic [CNT_W-1:0]  half_period,
  output logic              done,
  output logic              err,
  output logic              tone_out,
  output logic [1:0]        fsm_state   // 0 = IDLE, 1 = DIV, 2 = RUN
);

  localparam longint NUM = longint'(CLK_HZ) * 64'sd50;
  localparam int DIV_W = $clog2(NUM + 1);
  localparam int DC_W  = $clog2(DIV_W + 1);
  localparam int FX_W  = 15 + (1 << OCT_W) - 1;
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(NUM);
  localparam logic [63:0] HP_MAX = (64'd1 << CNT_W) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [FX_W-1:0]  fx_reg;
  logic [FX_W-1:0]  rem;
  logic [DIV_W-1:0] quo;
  logic [DC_W-1:0]  div_cnt;
  logic [FX_W:0]    rem_sh, rem_sub;
  logic [FX_W-1:0]  rem_nx;
  logic             q_bit;
  logic             div_last;
  logic [CNT_W-1:0] hp_sat;
  logic             accept_good, accept_bad;
  logic [CNT_W-1:0] hp_act;
  logic [CNT_W-1:0] cnt;
  logic             active;

  // Base pitches in Hz x100 for octave 3, C through B.
  function automatic logic [14:0] base_hz100(input logic [3:0] n);
    case (n)
      4'd0:    base_hz100 = 15'd13081;
      4'd1:    base_hz100 = 15'd13859;
      4'd2:    base_hz100 = 15'd14683;
      4'd3:    base_hz100 = 15'd15556;
      4'd4:    base_hz100 = 15'd16481;
      4'd5:    base_hz100 = 15'd17461;
      4'd6:    base_hz100 = 15'd18500;
      4'd7:    base_hz100 = 15'd19600;
      4'd8:    base_hz100 = 15'd20765;
      4'd9:    base_hz100 = 15'd22000;
      4'd10:   base_hz100 = 15'd23308;
      4'd11:   base_hz100 = 15'd24694;
      default: base_hz100 = 15'd0;
    endcase
  endfunction

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready is low only while a division is in flight, and the request is not retried.
  always_comb begin
    in_ready    = (state != S_DIV);
    accept_good = in_valid && in_ready && (note <= 4'd11);
    accept_bad  = in_valid && in_ready && (note > 4'd11);
    div_last    = (div_cnt == DC_W'(DIV_W));
    state_next  = state;
    case (state)
      S_IDLE, S_RUN: if (accept_good) state_next = S_DIV;
      S_DIV:         if (div_last) state_next = S_RUN;
      default:       state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rem_sh  = {rem, quo[DIV_W-1]};
    rem_sub = rem_sh - {1'b0, fx_reg};
    q_bit   = (rem_sh >= {1'b0, fx_reg});
    rem_nx  = q_bit ? FX_W'(rem_sub) : FX_W'(rem_sh);
    if (64'(quo) > HP_MAX)  hp_sat = CNT_W'(HP_MAX);
    else if (quo == '0)     hp_sat = CNT_W'(1);
    else                    hp_sat = CNT_W'(quo);
  end

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fx_reg      <= '0;
      rem         <= '0;
      quo         <= '0;
      div_cnt     <= '0;
      freq        <= '0;
      half_period <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= accept_bad;
      if (accept_good) begin
        fx_reg  <= FX_W'(base_hz100(note)) << octave;
        rem     <= '0;
        quo     <= DIVIDEND;
        div_cnt <= '0;
      end else if (state == S_DIV) begin
        if (div_last) begin
          freq        <= FREQ_W'(fx_reg / FX_W'(100));
          half_period <= hp_sat;
          done        <= 1'b1;
        end else begin
          rem     <= rem_nx;
          quo     <= {quo[DIV_W-2:0], q_bit};
          div_cnt <= div_cnt + DC_W'(1);
        end
      end
    end
  end

  // The running half-period only picks up a new value at a wrap, so a retune never cuts a half-cycle.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      active   <= 1'b0;
      cnt      <= '0;
      tone_out <= 1'b0;
      if (rst) hp_act <= '0;
    end else if (active) begin
      if (cnt == hp_act - CNT_W'(1)) begin
        cnt      <= '0;
        tone_out <= ~tone_out;
        hp_act   <= half_period;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (state == S_RUN) begin
      active   <= 1'b1;
      cnt      <= '0;
      tone_out <= 1'b1;
      hp_act   <= half_period;
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: a full-rate instance checks pitch values, a slow-clock
// instance driven by the same inputs checks tone timing in a short run.
module tb_note_tone_gen;

  localparam int OCT_W  = 2;
  localparam int FREQ_W = 20;
  localparam int CNT_W  = 24;
  localparam longint CLK_A = 50_000_000;
  localparam longint CLK_B = 50_000;
  localparam int DIVW_A = 32;   // 2.5e9 needs 32 bits
  localparam int DIVW_B = 22;   // 2.5e6 needs 22 bits
  localparam int SB_W = 32 + FREQ_W + CNT_W;
  localparam int BASE[12] = '{13081, 13859, 14683, 15556, 16481, 17461,
                              18500, 19600, 20765, 22000, 23308, 24694};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic enable = 1'b0;
  logic [3:0] note = '0;
  logic [OCT_W-1:0] octave = '0;

  logic in_ready_a, done_a, err_a, tone_a;
  logic in_ready_b, done_b, err_b, tone_b;
  logic [FREQ_W-1:0] freq_a, freq_b;
  logic [CNT_W-1:0] hp_a, hp_b;
  logic [1:0] st_a, st_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [SB_W-1:0] exp_a_q[$];
  logic [SB_W-1:0] exp_b_q[$];
  int tog_q[$];
  logic tone_b_prev = 1'b0;

  note_tone_gen #(.CLK_HZ(int'(CLK_A)), .OCT_W(OCT_W), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .note(note),
    .octave(octave), .enable(enable), .freq(freq_a), .half_period(hp_a), .done(done_a),
    .err(err_a), .tone_out(tone_a), .fsm_state(st_a));

  note_tone_gen #(.CLK_HZ(int'(CLK_B)), .OCT_W(OCT_W), .FREQ_W(FREQ_W), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .note(note),
    .octave(octave), .enable(enable), .freq(freq_b), .half_period(hp_b), .done(done_b),
    .err(err_b), .tone_out(tone_b), .fsm_state(st_b));

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [SB_W-1:0] model(input int n, input int o, input longint clk_hz,
                                            input int due);
    longint fx, f, hp;
    fx = longint'(BASE[n]) << o;
    f  = fx / 100;
    hp = (clk_hz * 50) / fx;
    if (hp > (longint'(1) << CNT_W) - 1) hp = (longint'(1) << CNT_W) - 1;
    if (hp < 1) hp = 1;
    return {due[31:0], f[FREQ_W-1:0], hp[CNT_W-1:0]};
  endfunction

  task automatic push_req(input int n, input int o, input int acc_edge);
    exp_a_q.push_back(model(n, o, CLK_A, acc_edge + DIVW_A + 1));
    exp_b_q.push_back(model(n, o, CLK_B, acc_edge + DIVW_B + 1));
  endtask

  // Scoreboard: every done pulse pops one expected tone and its due cycle.
  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (done_a) begin
      if (exp_a_q.size() == 0) check("done_a_spurious", 1, 0);
      else begin
        e = exp_a_q.pop_front();
        check("done_a_cycle", cyc, e[SB_W-1 -: 32]);
        check("freq_a", freq_a, e[FREQ_W+CNT_W-1 -: FREQ_W]);
        check("hp_a", hp_a, e[CNT_W-1:0]);
      end
    end
    if (done_b) begin
      if (exp_b_q.size() == 0) check("done_b_spurious", 1, 0);
      else begin
        e = exp_b_q.pop_front();
        check("done_b_cycle", cyc, e[SB_W-1 -: 32]);
        check("freq_b", freq_b, e[FREQ_W+CNT_W-1 -: FREQ_W]);
        check("hp_b", hp_b, e[CNT_W-1:0]);
      end
    end
    if (tone_b !== tone_b_prev) tog_q.push_back(cyc);
    tone_b_prev = tone_b;
  end

  // Driver tasks
  task automatic send(input int n, input int o);
    @(negedge clk);
    check("ready_a_before_req", in_ready_a, 1);
    check("ready_b_before_req", in_ready_b, 1);
    in_valid = 1'b1;
    note = 4'(n);
    octave = OCT_W'(o);
    if (n < 12) push_req(n, o, cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++)
      @(negedge clk);
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  task automatic tog_reset();
    @(negedge clk);
    #1 tog_q.delete();
  endtask

  task automatic wait_tog(input int k, input int limit, output bit ok);
    for (int i = 0; i < limit && tog_q.size() < k; i++) @(negedge clk);
    ok = (tog_q.size() >= k);
    check("toggle_count", ok, 1);
  endtask

  task automatic check_rst_state();
    check("rst_freq_a", freq_a, 0);       check("rst_freq_b", freq_b, 0);
    check("rst_hp_a", hp_a, 0);           check("rst_hp_b", hp_b, 0);
    check("rst_done_a", done_a, 0);       check("rst_done_b", done_b, 0);
    check("rst_err_a", err_a, 0);         check("rst_err_b", err_b, 0);
    check("rst_tone_a", tone_a, 0);       check("rst_tone_b", tone_b, 0);
    check("rst_ready_a", in_ready_a, 1);  check("rst_ready_b", in_ready_b, 1);
    check("rst_state_a", st_a, 0);        check("rst_state_b", st_b, 0);
  endtask

  initial begin
    bit ok;
    int n, o, t0, ren;

    // Reset
    repeat (3) @(negedge clk);
    check_rst_state();
    rst = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_tone_b", tone_b, 0);

    // A3: 220 Hz, divider latency via scoreboard
    send(9, 0);
    check("div_ready_a", in_ready_a, 0);
    check("div_state_a", st_a, 1);
    check("div_tone_a", tone_a, 0);
    drain();
    check("a3_freq", freq_a, 220);
    check("a3_hp", hp_a, 113636);
    check("a3_hp_b", hp_b, 113);
    check("run_state_a", st_a, 2);

    // Steady tone period
    tog_reset();
    wait_tog(3, 500, ok);
    if (ok) begin
      check("a3_half1", tog_q[1] - tog_q[0], 113);
      check("a3_half2", tog_q[2] - tog_q[1], 113);
    end
    check("a3_tone_a_high", tone_a, 1);

    // Retune mid half-cycle: old half-cycle completes, then new period
    tog_reset();
    wait_tog(1, 300, ok);
    repeat (20) @(negedge clk);
    send(9, 1);
    wait_tog(4, 500, ok);
    if (ok) begin
      t0 = tog_q[0];
      check("retune_old_half", tog_q[1] - t0, 113);
      check("retune_new_half1", tog_q[2] - tog_q[1], 56);
      check("retune_new_half2", tog_q[3] - tog_q[2], 56);
    end
    drain();

    // Enable drop mid high phase, then re-enable
    for (int i = 0; i < 200 && tone_b !== 1'b0; i++) @(negedge clk);
    for (int i = 0; i < 200 && tone_b !== 1'b1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_tone_b", tone_b, 0);
    check("dis_tone_a", tone_a, 0);
    repeat (5) @(negedge clk);
    check("dis_hold_tone_b", tone_b, 0);
    @(negedge clk);
    #1 tog_q.delete();
    enable = 1'b1;
    ren = cyc;
    wait_tog(2, 300, ok);
    if (ok) begin
      check("reen_start", tog_q[0] - ren, 1);
      check("reen_high_len", tog_q[1] - tog_q[0], 56);
    end
    check("reen_tone_a", tone_a, 1);

    // C6
    send(0, 3);
    drain();
    check("c6_freq", freq_a, 1046);
    check("c6_hp", hp_a, 23889);

    // Rejected notes
    @(negedge clk);
    in_valid = 1'b1;
    note = 4'd12;
    @(negedge clk);
    in_valid = 1'b0;
    check("bad_err_a", err_a, 1);
    check("bad_err_b", err_b, 1);
    check("bad_done_a", done_a, 0);
    check("bad_ready_a", in_ready_a, 1);
    check("bad_state_a", st_a, 2);
    check("bad_freq_a", freq_a, 1046);
    check("bad_hp_a", hp_a, 23889);
    @(negedge clk);
    check("bad_err_a_one_cycle", err_a, 0);
    send(12 + $urandom_range(3), 0);
    check("bad2_err_b", err_b, 1);
    repeat (40) @(negedge clk);

    // Random legal notes
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(11);
      o = $urandom_range(3);
      send(n, o);
      drain();
    end

    // Request held through DIV: re-accepted right after each done
    @(negedge clk);
    in_valid = 1'b1;
    note = 4'd2;
    octave = 2'd0;
    t0 = cyc;
    exp_a_q.push_back(model(2, 0, CLK_A, t0 + 1 + DIVW_A + 1));
    exp_a_q.push_back(model(2, 0, CLK_A, t0 + DIVW_A + 3 + DIVW_A + 1));
    exp_b_q.push_back(model(2, 0, CLK_B, t0 + 1 + DIVW_B + 1));
    exp_b_q.push_back(model(2, 0, CLK_B, t0 + DIVW_B + 3 + DIVW_B + 1));
    repeat (35) @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset 10 cycles into DIV
    send(5, 2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    @(negedge clk);
    check_rst_state();
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // Reset wins over a simultaneous request
    rst = 1'b1;
    in_valid = 1'b1;
    note = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_req_state_a", st_a, 0);
    check("rst_req_ready_a", in_ready_a, 1);
    repeat (50) @(negedge clk);
    check("rst_req_idle_a", st_a, 0);
    check("rst_req_idle_b", st_b, 0);
    check("rst_req_tone_b", tone_b, 0);

    check("final_q_a", exp_a_q.size(), 0);
    check("final_q_b", exp_b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
